// File: rtl/uart_arb_pkg.sv
// Shared types and width helpers for the UART TX arbiter.
//   arb_state_e : arbiter FSM states
//   req_idx_w() : width of an encoded requester index
//   wd_cnt_w()  : width of the watchdog counter for a given timeout
package uart_arb_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    SEND   = 3'd2,
    WAIT   = 3'd3,
    LOCK   = 3'd4
  } arb_state_e;

  // Index width, never narrower than one bit.
  function automatic int req_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Counter only needs to reach TIMEOUT_CYC-1.
  function automatic int wd_cnt_w(input int t);
    return (t > 1) ? $clog2(t) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Rotate-priority picker: finds the first asserted request searching
// ptr+1, ptr+2, ... with wrap. Purely combinational.
//   req : request vector
//   ptr : index of the last winner (lowest priority this round)
//   any : at least one request asserted
//   gnt : one-hot winner
//   idx : encoded winner
module rr_picker #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic               any,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   idx
);

  always_comb begin
    int k;
    k   = 0;
    any = 1'b0;
    gnt = '0;
    idx = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      k = (int'(ptr) + i) % NUM_REQ;
      if (!any && req[k]) begin
        any    = 1'b1;
        gnt[k] = 1'b1;
        idx    = IDX_W'(k);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing one UART transmitter among
// NUM_REQ byte-stream requesters, with a watchdog that frees a stalled grant.
//   clk, rst             : clock, async active-high reset
//   req_valid_i/data/last: per-requester byte stream (valid/ready)
//   req_ready_o          : one-cycle accept strobe for the owner
//   grant_o, busy_o      : current owner (one-hot) / transmitter owned
//   tx_start_o, tx_data_o: start pulse and byte to the UART
//   tx_done_i            : TX-complete pulse from the UART
//   timeout_o            : one-cycle pulse on watchdog release
module uart_tx_arbiter
  import uart_arb_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 8,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
  input  logic [NUM_REQ-1:0]        req_last_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  output logic [NUM_REQ-1:0]        grant_o,
  output logic                      busy_o,
  output logic                      tx_start_o,
  output logic [DATA_W-1:0]         tx_data_o,
  input  logic                      tx_done_i,
  output logic                      timeout_o
);

  localparam int REQ_IDX_W = req_idx_w(NUM_REQ);
  localparam int CNT_W     = wd_cnt_w(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  arb_state_e state_q, state_d;
  logic [REQ_IDX_W-1:0] ptr_q, ptr_d, idx_q, idx_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 last_q, last_d;
  logic [NUM_REQ-1:0]   grant_d, ready_d;
  logic [DATA_W-1:0]    data_d;
  logic                 busy_d, start_d, timeout_d;

  logic [NUM_REQ-1:0][DATA_W-1:0] req_data_v;
  logic                 pick_any;
  logic [NUM_REQ-1:0]   pick_gnt;
  logic [REQ_IDX_W-1:0] pick_idx;
  logic                 in_wd, wd_hit;

  assign req_data_v = req_data_i;

  rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(REQ_IDX_W)) u_pick (
    .req (req_valid_i),
    .ptr (ptr_q),
    .any (pick_any),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  assign in_wd  = (state_q == WAIT) || (state_q == LOCK);
  assign wd_hit = (TIMEOUT_CYC != 0) && in_wd && (cnt_q == WD_LAST);

  // Next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:   if (pick_any) state_d = ACCEPT;
      ACCEPT: state_d = SEND;
      SEND:   state_d = WAIT;
      WAIT: begin
        // done beats a coinciding watchdog hit
        if (tx_done_i)
          state_d = last_q ? IDLE : (req_valid_i[idx_q] ? ACCEPT : LOCK);
        else if (wd_hit)
          state_d = IDLE;
      end
      LOCK: begin
        if (req_valid_i[idx_q]) state_d = ACCEPT;
        else if (wd_hit)        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next register values; every output is a flop fed from here
  always_comb begin
    grant_d = grant_o;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    data_d  = tx_data_o;
    last_d  = last_q;
    cnt_d   = cnt_q;
    if (state_q == IDLE && state_d == ACCEPT) begin
      grant_d = pick_gnt;
      idx_d   = pick_idx;
    end else if (state_d == IDLE) begin
      grant_d = '0;
    end
    // Releasing owner becomes lowest priority for the next round
    if (state_q != IDLE && state_d == IDLE) ptr_d = idx_q;
    // Handshake completes on the ACCEPT edge
    if (state_q == ACCEPT) begin
      data_d = req_data_v[idx_q];
      last_d = req_last_i[idx_q];
    end
    if (state_d != state_q) cnt_d = '0;
    else if (in_wd)         cnt_d = cnt_q + CNT_W'(1);
    ready_d   = (state_d == ACCEPT) ? grant_d : '0;
    busy_d    = (state_d != IDLE);
    start_d   = (state_d == SEND);
    timeout_d = wd_hit && (state_d == IDLE) && !(state_q == WAIT && tx_done_i);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      ptr_q       <= REQ_IDX_W'(NUM_REQ - 1);
      idx_q       <= '0;
      cnt_q       <= '0;
      last_q      <= 1'b0;
      grant_o     <= '0;
      req_ready_o <= '0;
      busy_o      <= 1'b0;
      tx_start_o  <= 1'b0;
      tx_data_o   <= '0;
      timeout_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      last_q      <= last_d;
      grant_o     <= grant_d;
      req_ready_o <= ready_d;
      busy_o      <= busy_d;
      tx_start_o  <= start_d;
      tx_data_o   <= data_d;
      timeout_o   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
module tb_uart_tx_arbiter;
  localparam int NR = 4;
  localparam int DW = 8;
  localparam int TO = 100;

  logic              clk = 1'b0;
  logic              rst;
  logic [NR-1:0]     req_valid_i, req_last_i, req_ready_o, grant_o;
  logic [NR*DW-1:0]  req_data_i;
  logic              busy_o, tx_start_o, tx_done_i, timeout_o;
  logic [DW-1:0]     tx_data_o;

  int n_assert = 0;
  int n_fail   = 0;

  logic [8:0] rq[NR][$];      // per-requester {last, data} stream
  int         sb_idx[$];      // expected owner per start pulse
  logic [7:0] sb_dat[$];      // expected byte per start pulse
  bit         hs[NR];
  int         uart_delay = 10;
  bit         uart_en = 1'b1;
  int         done_cd = -1;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_last_i  (req_last_i),
    .req_ready_o (req_ready_o),
    .grant_o     (grant_o),
    .busy_o      (busy_o),
    .tx_start_o  (tx_start_o),
    .tx_data_o   (tx_data_o),
    .tx_done_i   (tx_done_i),
    .timeout_o   (timeout_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic push(input int k, input bit last, input logic [7:0] d);
    rq[k].push_back({last, d});
  endtask

  task automatic expect_tx(input int k, input logic [7:0] d);
    sb_idx.push_back(k);
    sb_dat.push_back(d);
  endtask

  function automatic bit rq_empty();
    for (int k = 0; k < NR; k++) if (rq[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic drain(input string tag, input int max);
    int n;
    n = 0;
    while ((busy_o || sb_idx.size() != 0 || !rq_empty()) && n < max) begin
      cyc(1);
      n++;
    end
    chk(tag, 32'(n < max), 32'd1);
  endtask

  task automatic wait_start(input string tag);
    int n;
    n = 0;
    while (!tx_start_o && n < 10) begin cyc(1); n++; end
    chk(tag, 32'(tx_start_o), 32'd1);
  endtask

  // Requester drivers: present queue head, pop one cycle after the handshake
  initial begin
    logic [8:0] e;
    req_valid_i = '0;
    req_last_i  = '0;
    req_data_i  = '0;
    forever begin
      @(negedge clk);
      for (int k = 0; k < NR; k++) begin
        if (hs[k] && rq[k].size() > 0) void'(rq[k].pop_front());
        hs[k] = 1'b0;
        if (rq[k].size() > 0) begin
          e = rq[k][0];
          req_valid_i[k]        = 1'b1;
          req_data_i[k*DW +: DW] = e[7:0];
          req_last_i[k]         = e[8];
        end else begin
          req_valid_i[k] = 1'b0;
        end
        hs[k] = req_valid_i[k] & req_ready_o[k];
      end
    end
  end

  // UART model + scoreboard checker
  initial begin
    int         k;
    logic [7:0] d;
    tx_done_i = 1'b0;
    forever begin
      @(negedge clk);
      tx_done_i = 1'b0;
      if (done_cd == 0) begin
        tx_done_i = 1'b1;
        done_cd   = -1;
      end else if (done_cd > 0) begin
        done_cd--;
      end
      if (tx_start_o) begin
        chk("sb_expected", 32'(sb_idx.size() != 0), 32'd1);
        if (sb_idx.size() != 0) begin
          k = sb_idx.pop_front();
          d = sb_dat.pop_front();
          chk("sb_grant", 32'(grant_o), 32'(1) << k);
          chk("sb_data", 32'(tx_data_o), 32'(d));
        end
        if (uart_en) done_cd = uart_delay - 1;
      end
    end
  end

  initial begin
    #500000;
    $fatal(1, "FAIL global_timeout n_assert=%0d", n_assert);
  end

  initial begin
    bit seen;
    int m;
    rst = 1'b1;
    cyc(3);
    chk("reset_outputs", 32'({grant_o, req_ready_o, busy_o, tx_start_o, timeout_o, tx_data_o}), 32'd0);
    rst = 1'b0;
    cyc(1);

    // Single byte, latency 1 to ready, 2 to start
    push(0, 1'b1, 8'h5A);
    expect_tx(0, 8'h5A);
    cyc(1);
    chk("single_ready", 32'(req_ready_o), 32'h1);
    chk("single_grant", 32'(grant_o), 32'h1);
    chk("single_busy", 32'(busy_o), 32'd1);
    cyc(1);
    chk("single_start", 32'(tx_start_o), 32'd1);
    chk("single_data", 32'(tx_data_o), 32'h5A);
    chk("single_ready_once", 32'(req_ready_o), 32'h0);
    cyc(10);
    chk("single_busy_before_done", 32'(busy_o), 32'd1);
    cyc(1);
    chk("single_release_busy", 32'(busy_o), 32'd0);
    chk("single_release_grant", 32'(grant_o), 32'h0);
    chk("single_data_hold", 32'(tx_data_o), 32'h5A);

    // Packet lock: req1 keeps the grant for its whole packet
    push(2, 1'b1, 8'h20);
    push(1, 1'b0, 8'h01);
    push(1, 1'b0, 8'h02);
    push(1, 1'b1, 8'h03);
    expect_tx(1, 8'h01);
    expect_tx(1, 8'h02);
    expect_tx(1, 8'h03);
    expect_tx(2, 8'h20);
    drain("pkt_lock_drain", 300);

    // Round robin from reset pointer
    rst = 1'b1;
    cyc(2);
    rst = 1'b0;
    push(0, 1'b1, 8'hA0);
    push(0, 1'b1, 8'hA4);
    push(1, 1'b1, 8'hA1);
    push(2, 1'b1, 8'hA2);
    push(3, 1'b1, 8'hA3);
    expect_tx(0, 8'hA0);
    expect_tx(1, 8'hA1);
    expect_tx(2, 8'hA2);
    expect_tx(3, 8'hA3);
    expect_tx(0, 8'hA4);
    drain("rr_all_drain", 400);
    push(1, 1'b1, 8'hB1);
    push(1, 1'b1, 8'hB2);
    push(3, 1'b1, 8'hB3);
    expect_tx(1, 8'hB1);
    expect_tx(3, 8'hB3);
    expect_tx(1, 8'hB2);
    drain("rr_pair_drain", 300);

    // LOCK then resume
    push(0, 1'b0, 8'hAA);
    expect_tx(0, 8'hAA);
    cyc(1);
    chk("lock_first_grant", 32'(grant_o), 32'h1);
    push(2, 1'b1, 8'h22);
    cyc(30);
    chk("lock_hold_grant", 32'(grant_o), 32'h1);
    chk("lock_hold_busy", 32'(busy_o), 32'd1);
    chk("lock_no_ready", 32'(req_ready_o), 32'h0);
    cyc(20);
    chk("lock_hold_grant2", 32'(grant_o), 32'h1);
    push(0, 1'b1, 8'hBB);
    expect_tx(0, 8'hBB);
    expect_tx(2, 8'h22);
    drain("lock_drain", 300);

    // Watchdog with a silent UART
    uart_en = 1'b0;
    push(1, 1'b1, 8'h77);
    expect_tx(1, 8'h77);
    wait_start("wd_start_seen");
    m = 0;
    do begin cyc(1); m++; end while (!timeout_o && m < 200);
    chk("wd_latency", 32'(m), 32'd101);
    chk("wd_grant_clear", 32'(grant_o), 32'h0);
    chk("wd_busy_clear", 32'(busy_o), 32'd0);
    cyc(1);
    chk("wd_pulse_width", 32'(timeout_o), 32'd0);
    uart_en = 1'b1;

    // done coinciding with the watchdog hit
    uart_delay = TO;
    push(3, 1'b1, 8'h33);
    expect_tx(3, 8'h33);
    wait_start("coin_start_seen");
    seen = 1'b0;
    for (int i = 1; i <= 101; i++) begin
      cyc(1);
      seen |= timeout_o;
      if (i == 100) chk("coin_busy_last_wait", 32'(busy_o), 32'd1);
    end
    chk("coin_no_timeout", 32'(seen), 32'd0);
    chk("coin_release_busy", 32'(busy_o), 32'd0);
    chk("coin_release_grant", 32'(grant_o), 32'h0);
    uart_delay = 10;

    // Reset mid-WAIT
    push(2, 1'b1, 8'h44);
    expect_tx(2, 8'h44);
    wait_start("rst_start_seen");
    cyc(1);
    rst = 1'b1;
    #1;
    chk("rst_async_outputs", 32'({grant_o, req_ready_o, busy_o, tx_start_o, timeout_o, tx_data_o}), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin cyc(1); seen |= tx_start_o; end
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin cyc(1); seen |= tx_start_o | busy_o; end
    chk("rst_quiet_after", 32'(seen), 32'd0);
    push(2, 1'b1, 8'h55);
    push(0, 1'b1, 8'h66);
    expect_tx(0, 8'h66);
    expect_tx(2, 8'h55);
    cyc(1);
    chk("rst_rr_first", 32'(grant_o), 32'h1);
    drain("rst_drain", 300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
